// File: rtl/gpio_bus_sched.sv
// gpio_bus_sched
// ---------------------------------------------------------------------------
// Two-requester round-robin scheduler in front of the GPIO register block.
// A granted access runs as address setup, an enable strobe held for
// ACC_CYCLES clocks, then one hold cycle in which the winner is acknowledged.
// Out-of-range addresses are answered with a one-cycle error acknowledge and
// never reach the GPIO block. This block owns all timing of the shared data
// bus: data_oe_o is the only thing that lets the top level drive it.
//
// Parameters
//   ACC_CYCLES  strobe length in clocks, 1..15
//   NUM_REGS    number of valid register addresses (0..NUM_REGS-1), 1..8
//
// Ports
//   clk_i                     system clock, rising edge
//   reset_ni                  asynchronous active-low reset
//   req0_i / req1_i           access request, held until the matching ack
//   we0_i / we1_i             1 = write, 0 = read
//   addr0_i / addr1_i         register address
//   wdata0_i / wdata1_i       write data
//   ack0_o / ack1_o           one-cycle completion pulse
//   err_o                     valid with ack: address was out of range
//   rdata_o                   read data, valid during ack of a read
//   add_reg_o                 register address to the GPIO block
//   r_en_o / w_en_o           read / write strobes to the GPIO block
//   data_out_o                write data for the shared data bus
//   data_oe_o                 shared data bus output enable
//   data_in_i                 shared data bus value, sampled on reads
//   busy_o                    high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | waiting; req/we/addr/wdata are only sampled here
// ST_SETUP  | add_reg (and write data) driven, strobes still low
// ST_ACCESS | r_en or w_en high, down-counter running to terminal count 0
// ST_HOLD   | strobes low, address/data held, winner's ack high
// ST_ERR    | out-of-range address: winner's ack high with err, no strobe

module gpio_bus_sched #(
    parameter int unsigned ACC_CYCLES = 4,
    parameter int unsigned NUM_REGS   = 3
) (
    input  logic       clk_i,
    input  logic       reset_ni,

    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       we0_i,
    input  logic       we1_i,
    input  logic [2:0] addr0_i,
    input  logic [2:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,

    output logic       ack0_o,
    output logic       ack1_o,
    output logic       err_o,
    output logic [7:0] rdata_o,

    output logic [2:0] add_reg_o,
    output logic       r_en_o,
    output logic       w_en_o,
    output logic [7:0] data_out_o,
    output logic       data_oe_o,
    input  logic [7:0] data_in_i,

    output logic       busy_o
);

    // Counter is loaded with ACC_CYCLES-1 so the strobe covers exactly
    // ACC_CYCLES clocks including the terminal-count cycle.
    localparam logic [3:0] ACC_LOAD   = 4'(ACC_CYCLES - 1);
    localparam logic [3:0] NUM_REGS_W = 4'(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_ERR
    } state_t;

    state_t     state_q;

    // round-robin pointer: requester served most recently
    logic       last_q;

    // transaction latched at grant
    logic       win_q;
    logic       we_q;
    logic [7:0] wdata_q;
    logic [3:0] cnt_q;

    // registered outputs
    logic       ack0_q;
    logic       ack1_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic [2:0] add_reg_q;
    logic       r_en_q;
    logic       w_en_q;
    logic [7:0] data_out_q;
    logic       data_oe_q;
    logic       busy_q;

    // arbitration result for the current IDLE cycle
    logic       win_d;
    logic       we_d;
    logic [2:0] addr_d;
    logic [7:0] wdata_d;
    logic       addr_ok_d;

    always_comb begin
        win_d = 1'b0;
        if (req0_i && req1_i) begin
            // tie goes to whoever was not served last
            win_d = ~last_q;
        end else begin
            win_d = req1_i;
        end
        we_d      = win_d ? we1_i    : we0_i;
        addr_d    = win_d ? addr1_i  : addr0_i;
        wdata_d   = win_d ? wdata1_i : wdata0_i;
        addr_ok_d = ({1'b0, addr_d} < NUM_REGS_W);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            cnt_q      <= 4'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            add_reg_q  <= 3'd0;
            r_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        win_q   <= win_d;
                        we_q    <= we_d;
                        wdata_q <= wdata_d;
                        busy_q  <= 1'b1;
                        if (addr_ok_d) begin
                            // address (and write data) go out one cycle
                            // ahead of the strobe
                            state_q   <= ST_SETUP;
                            add_reg_q <= addr_d;
                            data_oe_q <= we_d;
                            if (we_d) begin
                                data_out_q <= wdata_d;
                            end
                        end else begin
                            // bus untouched; answer straight away
                            state_q <= ST_ERR;
                            ack0_q  <= ~win_d;
                            ack1_q  <= win_d;
                            err_q   <= 1'b1;
                            rdata_q <= 8'h00;
                        end
                    end
                end

                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    r_en_q  <= ~we_q;
                    w_en_q  <= we_q;
                    cnt_q   <= ACC_LOAD;
                end

                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_HOLD;
                        r_en_q  <= 1'b0;
                        w_en_q  <= 1'b0;
                        ack0_q  <= ~win_q;
                        ack1_q  <= win_q;
                        err_q   <= 1'b0;
                        // last strobe edge: capture the bus for reads
                        rdata_q <= we_q ? 8'h00 : data_in_i;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_HOLD: begin
                    // add_reg and data_out stay put for hold time
                    state_q   <= ST_IDLE;
                    ack0_q    <= 1'b0;
                    ack1_q    <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    last_q    <= win_q;
                end

                ST_ERR: begin
                    state_q <= ST_IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    r_en_q    <= 1'b0;
                    w_en_q    <= 1'b0;
                    ack0_q    <= 1'b0;
                    ack1_q    <= 1'b0;
                    err_q     <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign add_reg_o  = add_reg_q;
    assign r_en_o     = r_en_q;
    assign w_en_o     = w_en_q;
    assign data_out_o = data_out_q;
    assign data_oe_o  = data_oe_q;
    assign busy_o     = busy_q;

    a_strobe_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(r_en_q && w_en_q));

    a_ack_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(ack0_q && ack1_q));

    a_strobe_in_access: assert property (@(posedge clk_i) disable iff (!reset_ni)
        (r_en_q || w_en_q) |-> (state_q == ST_ACCESS));

endmodule

// File: doc/gpio_bus_sched.md
# gpio_bus_sched

Two-requester bus scheduler in front of the GPIO register block. It arbitrates round-robin between requester 0 and requester 1. It sequences each granted access as address setup, then an enable strobe, then a hold phase on the GPIO block's `add_reg`/`r_en`/`w_en`/`data` interface. It returns read data and a one-cycle acknowledge to the winning requester. It sits between on-chip masters and the GPIO top-level, and it owns all timing of the shared data bus.

## Interface
- `ACC_CYCLES`, default 4: cycles `r_en`/`w_en` are held high per access; legal range 1..15.
- `NUM_REGS`, default 3: number of valid register addresses (0..NUM_REGS-1); legal range 1..8.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request, held until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; held stable with req.
- `addr0`, `addr1`  in  3  register address; held stable with req.
- `wdata0`, `wdata1`  in  8  write data; held stable with req.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with ack: address was out of range.
- `rdata`  out  8  read data; valid during ack of a read.
- `add_reg`  out  3  register address to the GPIO block.
- `r_en`, `w_en`  out  1  read and write strobes to the GPIO block.
- `data_out`  out  8  write data driven onto the shared data bus.
- `data_oe`  out  1  bus output enable; the top level tristates the bus when this is 0.
- `data_in`  in  8  bus value sampled on reads.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE
  - SETUP (1 cycle)
  - ACCESS (ACC_CYCLES cycles)
  - HOLD (1 cycle)
  - ERR (1 cycle)
- IDLE, no req: stay in IDLE.
- IDLE, any req: pick a winner and latch its we, addr and wdata into internal registers. The winner is latched as well.
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins.
  - `last` pointer resets to 1, so requester 0 wins the first tie.
- Latched addr >= NUM_REGS: go to ERR.
  - ERR pulses the winner's ack with err=1 and rdata=0.
  - No strobe, and add_reg is not updated.
  - Returns to IDLE and updates `last`.
- Valid address: go to SETUP.
  - SETUP drives add_reg = latched addr.
  - For a write, it also drives data_out = wdata and data_oe = 1. r_en and w_en stay 0.
- ACCESS holds add_reg, data_out and data_oe. r_en (read) or w_en (write) is 1 for exactly ACC_CYCLES cycles, counted by a down-counter.
- Read sampling: at the clock edge ending the last ACCESS cycle, data_in is registered into rdata.
- HOLD:
  - Strobes are 0. add_reg, data_out and data_oe are still held (hold time).
  - The winner's ack = 1 and err = 0.
  - Then go to IDLE, clear data_oe and update `last`.
- rdata keeps its value until the next read or ERR. It is 0 after a write ack and after an ERR ack.
- req, we, addr and wdata are sampled only in IDLE.
  - Changes after the grant are ignored.
  - Dropping req mid-transaction does not abort; the access completes and ack still pulses.
- req still high in the IDLE cycle after ack is a new request.
- r_en and w_en are never both 1. ack0 and ack1 are never both 1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE, last = 1.
  - All outputs = 0: add_reg, r_en, w_en, data_out, data_oe, ack0/1, err, rdata, busy.
- Reset asserted mid-transaction: the bus is released immediately and no ack is issued. The requester must re-request.
- Let req be sampled in IDLE at edge k.
  - SETUP occupies cycle k..k+1.
  - ACCESS occupies edges k+1 .. k+1+ACC_CYCLES.
  - HOLD/ack occupies the cycle after edge k+1+ACC_CYCLES.
- Valid access: ack high ACC_CYCLES+2 cycles after the grant edge.
- ERR: ack high 1 cycle after the grant edge.
- Back-to-back: at least one IDLE cycle between ack and the next SETUP.
- Default ACC_CYCLES=4: a valid access is 7 clocks from grant to the return to IDLE.
- Strobe low-to-high and high-to-low transitions never coincide with changes on add_reg or data_out.

## Test plan
- Read: req0, we0=0, addr0=0, data_in=8'hAF, ACC_CYCLES=4. Required response:
  - add_reg=0 from SETUP.
  - r_en high exactly 4 cycles, w_en stays 0.
  - ack0 6 cycles after the grant edge, with rdata=8'hAF and err=0.
- Write: req1, we1=1, addr1=2, wdata1=8'hCF. Required response:
  - data_oe=1 and data_out=8'hCF from SETUP through HOLD.
  - w_en high 4 cycles, r_en stays 0.
  - ack1 pulse, rdata=0.
  - data_oe=0 in the following IDLE.
- Contention: req0 and req1 held high continuously, reads to 0 and 1. Required response:
  - Grants alternate 0,1,0,1.
  - Each ack is a single cycle, never simultaneous.
  - At least one IDLE cycle between transactions.
- Bad address: req0 with addr0=5, NUM_REGS=3. Required response:
  - ack0 with err=1 one cycle after the grant.
  - No r_en or w_en pulse, and add_reg unchanged.
  - The next tie is granted to requester 1.
- Reset mid-ACCESS: assert reset in the 2nd strobe cycle of a write. Required response:
  - w_en, data_oe, busy and add_reg go to 0 asynchronously, with no ack.
  - After release, a tie is granted to requester 0.
- Stable-input rule: change addr0 from 1 to 2 and drop req0 during ACCESS. Required response:
  - add_reg stays 1 and the access completes.
  - ack0 still pulses.
